// File: rtl/zrb_uart_reg_bridge.sv
// ---------------------------------------------------------------------------
// ZrbUartRegBridge: turns short command frames received over a UART into
// 8-bit register bus transfers and answers with one response byte.
//
//   'W' addr data  -> register write, answers 'K' (or 'T' on bus timeout)
//   'R' addr       -> register read, answers the read byte (or 'T')
//   anything else  -> answers 'E' and pulses frame_err
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   rx_isr     in   RX FIFO non-empty, rx_data valid while high
//   rx_data    in   RX FIFO head byte (show-ahead)
//   rd         out  one-cycle pop strobe to the RX FIFO
//   tx_en      in   TX FIFO not full
//   tx_data    out  response byte to the TX FIFO
//   wr         out  one-cycle push strobe to the TX FIFO
//   reg_addr   out  register bus address
//   reg_wdata  out  register bus write data
//   reg_we     out  write request, held until ack or timeout
//   reg_re     out  read request, held until ack or timeout
//   reg_rdata  in   read data, valid with reg_ack
//   reg_ack    in   single-cycle completion from the register slave
//   busy       out  high whenever the bridge is not idle
//   frame_err  out  one-cycle pulse on a bad command or inter-byte timeout
// ---------------------------------------------------------------------------
module zrb_uart_reg_bridge #(
    parameter int unsigned IB_TIMEOUT  = 500000,
    parameter int unsigned BUS_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_isr,
    input  logic [7:0] rx_data,
    output logic       rd,
    input  logic       tx_en,
    output logic [7:0] tx_data,
    output logic       wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] GET_DATA = 3'd2;
    localparam logic [2:0] BUS_WR   = 3'd3;
    localparam logic [2:0] BUS_RD   = 3'd4;
    localparam logic [2:0] SEND     = 3'd5;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ERR   = 8'h45;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_TMO   = 8'h54;

    // Terminal counts: the timeout fires on the edge that would make the
    // counter reach the parameter value.
    localparam logic [23:0] IB_LAST  = 24'(IB_TIMEOUT - 1);
    localparam logic [7:0]  BUS_LAST = 8'(BUS_TIMEOUT - 1);

    logic [2:0]  state_q,   state_d;
    logic        opWr_q,    opWr_d;
    logic [7:0]  addr_q,    addr_d;
    logic [7:0]  wdata_q,   wdata_d;
    logic [7:0]  resp_q,    resp_d;
    logic [23:0] ibCnt_q,   ibCnt_d;
    logic [7:0]  busCnt_q,  busCnt_d;
    logic        ferr_q,    ferr_d;

    logic rxState;
    logic ibCounting;
    logic ibExpired;
    logic popNow;
    logic sendNow;

    // Byte-receiving states pop the FIFO as soon as it shows a byte; every
    // pop also moves the FSM on, so one visit never pops twice.
    assign rxState    = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
    assign popNow     = rx_isr && rxState && !reset;
    assign ibCounting = ((state_q == GET_ADDR) || (state_q == GET_DATA)) && !rx_isr;
    assign ibExpired  = ibCounting && (ibCnt_q == IB_LAST);
    assign sendNow    = (state_q == SEND) && tx_en && !reset;

    assign rd        = popNow;
    assign wr        = sendNow;
    assign tx_data   = resp_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = (state_q == BUS_WR) && !reset;
    assign reg_re    = (state_q == BUS_RD) && !reset;
    assign busy      = (state_q != IDLE);
    assign frame_err = ferr_q;

    // Next-state logic: command decoding, bus handshake with timeout and the
    // inter-byte watchdog. reg_ack is only looked at in the two bus states.
    always_comb begin
        state_d  = state_q;
        opWr_d   = opWr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        resp_d   = resp_q;
        busCnt_d = busCnt_q;
        ibCnt_d  = ibCnt_q;
        ferr_d   = 1'b0;

        if (popNow || ibExpired) begin
            ibCnt_d = '0;
        end else if (ibCounting) begin
            ibCnt_d = ibCnt_q + 24'd1;
        end

        case (state_q)
            IDLE: begin
                if (popNow) begin
                    if (rx_data == CMD_WRITE) begin
                        opWr_d  = 1'b1;
                        state_d = GET_ADDR;
                    end else if (rx_data == CMD_READ) begin
                        opWr_d  = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        resp_d  = RSP_ERR;
                        ferr_d  = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (popNow) begin
                    addr_d   = rx_data;
                    busCnt_d = '0;
                    state_d  = opWr_q ? GET_DATA : BUS_RD;
                end else if (ibExpired) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (popNow) begin
                    wdata_d  = rx_data;
                    busCnt_d = '0;
                    state_d  = BUS_WR;
                end else if (ibExpired) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUS_WR: begin
                // An ack in the last allowed cycle still counts as success.
                if (reg_ack) begin
                    resp_d  = RSP_OK;
                    state_d = SEND;
                end else if (busCnt_q == BUS_LAST) begin
                    resp_d  = RSP_TMO;
                    state_d = SEND;
                end else begin
                    busCnt_d = busCnt_q + 8'd1;
                end
            end
            BUS_RD: begin
                if (reg_ack) begin
                    resp_d  = reg_rdata;
                    state_d = SEND;
                end else if (busCnt_q == BUS_LAST) begin
                    resp_d  = RSP_TMO;
                    state_d = SEND;
                end else begin
                    busCnt_d = busCnt_q + 8'd1;
                end
            end
            SEND: begin
                // No timeout here: the response waits for TX space forever.
                if (tx_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so no stale
    // response or address can leak out after a mid-transaction reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opWr_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            resp_q   <= '0;
            ibCnt_q  <= '0;
            busCnt_q <= '0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opWr_q   <= opWr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
            ibCnt_q  <= ibCnt_d;
            busCnt_q <= busCnt_d;
            ferr_q   <= ferr_d;
        end
    end

endmodule

// File: tb/tb_zrb_uart_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_zrb_uart_reg_bridge: self-checking bench for zrb_uart_reg_bridge.
// An RX FIFO, a TX sink and a register slave are modelled around the DUT;
// expected responses come from a transaction-level model of the command
// protocol (bytes in -> response byte, bus cycles, frame errors).
// ---------------------------------------------------------------------------
module tb_zrb_uart_reg_bridge;

    localparam int IB_T  = 100;
    localparam int BUS_T = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_isr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_en = 1'b1;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;
    logic       rd, wr, reg_we, reg_re, busy, frame_err;
    logic [7:0] tx_data, reg_addr, reg_wdata;

    zrb_uart_reg_bridge #(.IB_TIMEOUT(IB_T), .BUS_TIMEOUT(BUS_T)) dut (
        .clk(clk), .reset(reset), .rx_isr(rx_isr), .rx_data(rx_data), .rd(rd),
        .tx_en(tx_en), .tx_data(tx_data), .wr(wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rxq[$];
    logic [7:0] txLog[$];
    logic [7:0] wmem[256];
    bit         written[256];
    logic [7:0] modelMem[256];

    int   ackDelay = 0;
    logic strayAck = 1'b0;
    int   reqCycles = 0;
    logic popPending = 1'b0;

    int   weHigh = 0, weBursts = 0, reHigh = 0, feHigh = 0, wrCount = 0, busViol = 0;
    logic weLast = 1'b0, busLast = 1'b0;
    logic [7:0] addrLast = 8'h00, wdataLast = 8'h00;

    // Register contents the slave returns before anything is written.
    function automatic logic [7:0] baseline(input logic [7:0] a);
        return a ^ 8'h1E;
    endfunction

    // RX FIFO and register slave, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (popPending && rxq.size() > 0) void'(rxq.pop_front());
        rx_isr  = (rxq.size() > 0);
        rx_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
        if (reg_we || reg_re) begin
            reqCycles = reqCycles + 1;
            reg_ack   = (reqCycles == ackDelay) || strayAck;
            reg_rdata = written[reg_addr] ? wmem[reg_addr] : baseline(reg_addr);
        end else begin
            reqCycles = 0;
            reg_ack   = strayAck;
        end
    end

    // Monitor on the falling edge: strobes, bus activity and slave writes.
    always @(negedge clk) begin
        popPending = rd;
        if (reg_we) weHigh = weHigh + 1;
        if (reg_we && !weLast) weBursts = weBursts + 1;
        weLast = reg_we;
        if (reg_re) reHigh = reHigh + 1;
        if (frame_err) feHigh = feHigh + 1;
        if (wr) begin
            wrCount = wrCount + 1;
            txLog.push_back(tx_data);
        end
        if (reg_we && reg_re) busViol = busViol + 1;
        if ((reg_we || reg_re) && busLast && (reg_addr != addrLast || reg_wdata != wdataLast))
            busViol = busViol + 1;
        busLast   = reg_we || reg_re;
        addrLast  = reg_addr;
        wdataLast = reg_wdata;
        if (reg_we && reg_ack) begin
            wmem[reg_addr]    = reg_wdata;
            written[reg_addr] = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pushByte(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full command frame, predicted by the protocol model and checked.
    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input int ack, input string tag);
        int nb, expWe, expRe, expFe;
        logic [7:0] resp;
        int w0, we0, wb0, re0, fe0, done;
        bit acked;
        expWe = 0; expRe = 0; expFe = 0; nb = 3;
        acked = (ack >= 1) && (ack <= BUS_T);
        if (b0 == 8'h57) begin
            if (acked) begin
                resp = 8'h4B; expWe = ack; modelMem[b1] = b2;
            end else begin
                resp = 8'h54; expWe = BUS_T;
            end
        end else if (b0 == 8'h52) begin
            nb = 2;
            if (acked) begin
                resp = modelMem[b1]; expRe = ack;
            end else begin
                resp = 8'h54; expRe = BUS_T;
            end
        end else begin
            nb = 1; resp = 8'h45; expFe = 1;
        end
        ackDelay = ack;
        w0 = wrCount; we0 = weHigh; wb0 = weBursts; re0 = reHigh; fe0 = feHigh;
        pushByte(b0);
        if (nb > 1) pushByte(b1);
        if (nb > 2) pushByte(b2);
        done = 0;
        for (int i = 0; i < 300 && done == 0; i++) begin
            tick();
            if (wrCount > w0) done = 1;
        end
        repeat (3) tick();
        checkOutput({tag, " done"}, done, 1);
        checkOutput({tag, " wr count"}, wrCount - w0, 1);
        checkOutput({tag, " tx byte"}, (wrCount > w0) ? int'(txLog[w0]) : -1, int'(resp));
        checkOutput({tag, " we cycles"}, weHigh - we0, expWe);
        checkOutput({tag, " we bursts"}, weBursts - wb0, (expWe > 0) ? 1 : 0);
        checkOutput({tag, " re cycles"}, reHigh - re0, expRe);
        checkOutput({tag, " frame_err"}, feHigh - fe0, expFe);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " rx left"}, rxq.size(), 0);
        if (b0 == 8'h57 && acked)
            checkOutput({tag, " reg write"}, written[b1] ? int'(wmem[b1]) : -1, int'(modelMem[b1]));
    endtask

    initial begin
        int w0, re0, fe0, tBusy, tFe, found;
        logic [7:0] rb0, ra, rdat;
        int sel, rack;

        for (int i = 0; i < 256; i++) modelMem[i] = baseline(8'(i));
        $display("[TB] start");

        // Reset state, with a byte waiting that must not be popped.
        pushByte(8'h57);
        repeat (3) tick();
        checkOutput("reset rd", rd, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset wr", wr, 0);
        checkOutput("reset reg_we", reg_we, 0);
        checkOutput("reset reg_re", reg_re, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset reg_addr", reg_addr, 0);
        checkOutput("reset reg_wdata", reg_wdata, 0);
        checkOutput("reset tx_data", tx_data, 0);
        checkOutput("reset no pop", rxq.size(), 1);
        rxq.delete();
        tick();
        reset = 1'b0;
        tick();

        // Directed write, read and bad-command frames.
        applyStimulus(8'h57, 8'h10, 8'hA5, 3, "write");
        applyStimulus(8'h52, 8'h22, 8'h00, 1, "read");
        checkOutput("read literal", int'(txLog[txLog.size() - 1]), 8'h3C);
        applyStimulus(8'h41, 8'h00, 8'h00, 1, "bad cmd");
        applyStimulus(8'h52, 8'h10, 8'h00, 2, "after bad");

        // Bus timeout boundary.
        applyStimulus(8'h52, 8'h30, 8'h00, 0, "bus tmo");
        applyStimulus(8'h52, 8'h31, 8'h00, 8, "ack last");
        applyStimulus(8'h57, 8'h32, 8'h77, 9, "ack late");
        applyStimulus(8'h57, 8'h33, 8'h5C, 8, "wr ack last");

        // Stray acks outside the bus states are ignored.
        w0 = wrCount; re0 = reHigh;
        strayAck = 1'b1; tick(); strayAck = 1'b0; tick(); tick();
        checkOutput("stray idle busy", busy, 0);
        pushByte(8'h52);
        repeat (5) tick();
        strayAck = 1'b1; tick(); strayAck = 1'b0; tick();
        checkOutput("stray addr busy", busy, 1);
        checkOutput("stray addr re", reHigh - re0, 0);
        ackDelay = 1;
        pushByte(8'h5A);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (wrCount > w0) found = 1;
        end
        checkOutput("stray read done", found, 1);
        checkOutput("stray read tx", (wrCount > w0) ? int'(txLog[w0]) : -1, int'(modelMem[8'h5A]));
        checkOutput("stray read re", reHigh - re0, 1);

        // Inter-byte timeout: measured from the first busy cycle.
        repeat (3) tick();
        w0 = wrCount; fe0 = feHigh; tBusy = -1; tFe = -1;
        pushByte(8'h57);
        for (int k = 0; k < 400 && tFe < 0; k++) begin
            tick();
            if (busy && tBusy < 0) tBusy = k;
            if (frame_err && tFe < 0) tFe = k;
        end
        repeat (3) tick();
        checkOutput("ib found", (tFe >= 0) ? 1 : 0, 1);
        checkOutput("ib idle cycles", tFe - tBusy, IB_T);
        checkOutput("ib frame_err", feHigh - fe0, 1);
        checkOutput("ib no wr", wrCount - w0, 0);
        checkOutput("ib busy", busy, 0);
        applyStimulus(8'h52, 8'h01, 8'h00, 2, "after ib");

        // TX backpressure; a byte arriving in SEND stays queued.
        tx_en = 1'b0; ackDelay = 2;
        w0 = wrCount; re0 = reHigh; fe0 = feHigh;
        pushByte(8'h52); pushByte(8'h33);
        repeat (20) tick();
        checkOutput("bp re", reHigh - re0, 2);
        pushByte(8'h41);
        repeat (20) tick();
        checkOutput("bp no wr", wrCount - w0, 0);
        checkOutput("bp busy", busy, 1);
        checkOutput("bp tx_data", tx_data, int'(modelMem[8'h33]));
        checkOutput("bp rx held", rxq.size(), 1);
        tx_en = 1'b1;
        for (int i = 0; i < 100 && wrCount < w0 + 2; i++) tick();
        repeat (3) tick();
        checkOutput("bp wr count", wrCount - w0, 2);
        checkOutput("bp tx0", (wrCount > w0) ? int'(txLog[w0]) : -1, int'(modelMem[8'h33]));
        checkOutput("bp tx1", (wrCount > w0 + 1) ? int'(txLog[w0 + 1]) : -1, 8'h45);
        checkOutput("bp frame_err", feHigh - fe0, 1);

        // Reset pulsed in BUS_WR drops the request at once, no response.
        ackDelay = 0; w0 = wrCount; found = 0;
        pushByte(8'h57); pushByte(8'h44); pushByte(8'h99);
        for (int i = 0; i < 50 && found == 0; i++) begin
            tick();
            if (reg_we) found = 1;
        end
        checkOutput("rst in bus_wr", found, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst reg_we", reg_we, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst reg_addr", reg_addr, 0);
        checkOutput("rst wr", wr, 0);
        tick(); tick();
        reset = 1'b0;
        repeat (20) tick();
        checkOutput("rst no wr", wrCount - w0, 0);
        checkOutput("rst no write", written[8'h44], 0);
        checkOutput("rst idle", busy, 0);
        applyStimulus(8'h52, 8'h44, 8'h00, 4, "after rst");

        // Randomized frames against the protocol model.
        for (int t = 0; t < 12; t++) begin
            sel  = $urandom_range(0, 9);
            ra   = {5'b10100, 3'($urandom_range(0, 7))};
            rdat = 8'($urandom);
            rack = $urandom_range(0, 10);
            if (sel < 4) rb0 = 8'h57;
            else if (sel < 8) rb0 = 8'h52;
            else begin
                rb0 = 8'($urandom);
                if (rb0 == 8'h57 || rb0 == 8'h52) rb0 = 8'h00;
            end
            applyStimulus(rb0, ra, rdat, rack, $sformatf("rand%0d", t));
        end

        checkOutput("bus protocol", busViol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zrb_uart_reg_bridge.md
ZRB_UART_REG_BRIDGE -- requirements
Module: zrb_uart_reg_bridge

Interface
REQ-001 Parameter IB_TIMEOUT, default 500000, is the idle clock count allowed between bytes of one command.
REQ-002 Parameter BUS_TIMEOUT, default 64, is the clock count allowed for reg_ack before the transfer is aborted.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_isr  input  1  UART RX FIFO non-empty; rx_data valid while high.
REQ-006 rx_data  input  8  head byte of the RX FIFO (show-ahead).
REQ-007 rd  output  1  one-cycle pop strobe to the RX FIFO.
REQ-008 tx_en  input  1  UART TX FIFO not full.
REQ-009 tx_data  output  8  response byte to the TX FIFO.
REQ-010 wr  output  1  one-cycle push strobe to the TX FIFO.
REQ-011 reg_addr  output  8  register bus address.
REQ-012 reg_wdata  output  8  register bus write data.
REQ-013 reg_we  output  1  write request, held until ack or timeout.
REQ-014 reg_re  output  1  read request, held until ack or timeout.
REQ-015 reg_rdata  input  8  read data, valid when reg_ack is high.
REQ-016 reg_ack  input  1  single-cycle completion from the register slave.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 frame_err  output  1  one-cycle pulse on a bad command or an inter-byte timeout.

Function
REQ-019 The FSM SHALL use the states IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD and SEND.
REQ-020 rd SHALL equal rx_isr AND (state in IDLE/GET_ADDR/GET_DATA) AND NOT reset; rx_data is captured on that same edge, and at most one pop occurs per state visit.
REQ-021 IDLE: byte 0x57 ('W') -> GET_ADDR with op=write; 0x52 ('R') -> GET_ADDR with op=read; any other byte -> SEND with response 0x45 ('E') and a frame_err pulse.
REQ-022 GET_ADDR: the popped byte SHALL load reg_addr; op=write -> GET_DATA, op=read -> BUS_RD.
REQ-023 GET_DATA: the popped byte SHALL load reg_wdata; next state BUS_WR.
REQ-024 reg_we SHALL be high exactly while in BUS_WR, and reg_re exactly while in BUS_RD; reg_addr and reg_wdata SHALL stay stable throughout.
REQ-025 BUS_WR on reg_ack SHALL go to SEND with response 0x4B ('K'); BUS_RD on reg_ack SHALL capture reg_rdata as the response and go to SEND.
REQ-026 The 8-bit bus counter SHALL clear on entry to BUS_WR/BUS_RD and count each cycle without ack; reaching BUS_TIMEOUT SHALL go to SEND with response 0x54 ('T').
REQ-027 If reg_ack arrives in the timeout cycle, ack SHALL win.
REQ-028 The 24-bit inter-byte counter SHALL clear on every pop and count in GET_ADDR/GET_DATA while rx_isr is low.
REQ-029 Reaching IB_TIMEOUT SHALL return the FSM to IDLE with a frame_err pulse and no response byte.
REQ-030 wr SHALL equal (state==SEND) AND tx_en AND NOT reset, with tx_data = response register; on that edge the FSM returns to IDLE.
REQ-031 SEND with tx_en low SHALL hold indefinitely, with no timeout and tx_data stable.
REQ-032 Latency: final command byte popped -> strobe next cycle; reg_ack -> wr no earlier than the next cycle.
REQ-033 reg_ack arriving outside BUS_WR/BUS_RD SHALL be ignored.
REQ-034 Bytes arriving while in BUS_* or SEND SHALL remain in the RX FIFO; they are not popped.

Reset
REQ-035 While reset is high, the state SHALL be IDLE and rd, wr, reg_we, reg_re, frame_err, and busy SHALL be 0.
REQ-036 While reset is high, reg_addr, reg_wdata, tx_data, and both counters SHALL be 0.
REQ-037 Reset mid-transaction SHALL drop strobes immediately (asynchronously), with no partial response emitted.

Verification
REQ-038 Write: RX 0x57,0x10,0xA5, ack after 3 cycles -> one reg_we burst with addr 0x10, wdata 0xA5; one wr with tx_data 0x4B.
REQ-039 Read: RX 0x52,0x22, reg_rdata 0x3C with ack -> reg_re only, no reg_we; wr with tx_data 0x3C.
REQ-040 Bad command: RX 0x41 -> frame_err for one cycle; tx_data 0x45; returns to IDLE; next valid command still served.
REQ-041 Inter-byte timeout (IB_TIMEOUT=100): RX 0x57, then nothing for 100 cycles -> frame_err, IDLE, no wr; subsequent 0x52,0x01 works.
REQ-042 Bus timeout (BUS_TIMEOUT=8): read with no ack -> reg_re high exactly 8 cycles, then tx_data 0x54; also ack on cycle 8 -> data response, not 0x54.
REQ-043 Backpressure and reset: tx_en low 20 cycles in SEND -> no wr and busy held; reset pulsed in BUS_WR -> reg_we low same cycle, no response byte.
